// File: rtl/controller_fwft_fifo_pkg.sv
// Shared helpers for the controller FWFT FIFO.
package controller_fwft_fifo_pkg;

   // Bits needed to index v distinct values; returns 1 for v <= 2.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/controller_fwft_fifo_ram.sv
// Simple dual-port storage: sync write, registered read, read-before-write.
module controller_fwft_fifo_ram
   import controller_fwft_fifo_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/controller_fwft_fifo.sv
// First-word-fall-through FIFO: RAM body, one fetch in flight, 2-entry head buffer.
module controller_fwft_fifo
   import controller_fwft_fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int LEVEL_W    = clog2(FIFO_DEPTH + 1),
   parameter int ADDR_W     = clog2(FIFO_DEPTH)
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  wrEn,
   input  logic [FIFO_WIDTH-1:0] wrData,
   input  logic                  rdEn,
   input  logic [LEVEL_W-1:0]    wmarkLevel,
   input  logic                  clrErr,
   output logic [FIFO_WIDTH-1:0] rdData,
   output logic                  rdValid,
   output logic                  fifoFull,
   output logic                  fifoEmpty,
   output logic                  wMarkFull,
   output logic [LEVEL_W-1:0]    level,
   output logic                  overflow,
   output logic                  underflow
);

   logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LEVEL_W-1:0]    level_q, level_d, ram_cnt;
   logic [1:0]            buf_cnt_q, buf_cnt_d;
   logic [FIFO_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d, ram_rdata;
   logic                  fetch_vld_q, fetch;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic                  pop, push_ok;

   assign rdValid   = (buf_cnt_q != 2'd0);
   assign pop       = rdEn & rdValid;
   assign fifoFull  = (level_q == LEVEL_W'(FIFO_DEPTH));
   assign fifoEmpty = (level_q == '0);
   assign push_ok   = wrEn & (~fifoFull | pop);
   assign wMarkFull = (wmarkLevel != '0) && (level_q >= wmarkLevel);
   assign level     = level_q;
   assign rdData    = buf0_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

   // Entries still parked in RAM; fetch only when the head buffer is
   // guaranteed a free slot by the time the read data lands.
   assign ram_cnt = level_q - LEVEL_W'(buf_cnt_q) - LEVEL_W'(fetch_vld_q);
   assign fetch   = (ram_cnt != '0) &&
                    (({1'b0, buf_cnt_q} + {2'b0, fetch_vld_q}) <= (3'd1 + {2'b0, pop}));

   controller_fwft_fifo_ram #(
      .WIDTH  (FIFO_WIDTH),
      .DEPTH  (FIFO_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clock),
      .we_i    (push_ok),
      .waddr_i (wr_ptr_q),
      .wdata_i (wrData),
      .re_i    (fetch),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      buf0_d    = buf0_q;
      buf1_d    = buf1_q;
      buf_cnt_d = buf_cnt_q;
      if (push_ok)
         wr_ptr_d = (wr_ptr_q == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_W'(1);
      if (fetch)
         rd_ptr_d = (rd_ptr_q == ADDR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
      if (push_ok && !pop)      level_d = level_q + LEVEL_W'(1);
      else if (!push_ok && pop) level_d = level_q - LEVEL_W'(1);
      // Pop shifts the head first, then the landing read fills the next free slot.
      if (pop) begin
         buf0_d    = buf1_q;
         buf_cnt_d = buf_cnt_q - 2'd1;
      end
      if (fetch_vld_q) begin
         if (buf_cnt_d == 2'd0) buf0_d = ram_rdata;
         else                   buf1_d = ram_rdata;
         buf_cnt_d = buf_cnt_d + 2'd1;
      end
      ovf_d = (wrEn & ~push_ok) | (ovf_q & ~clrErr);
      udf_d = (rdEn & ~rdValid) | (udf_q & ~clrErr);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         buf0_q      <= '0;
         buf1_q      <= '0;
         buf_cnt_q   <= 2'd0;
         fetch_vld_q <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         buf0_q      <= buf0_d;
         buf1_q      <= buf1_d;
         buf_cnt_q   <= buf_cnt_d;
         fetch_vld_q <= fetch;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
      end
   end

endmodule

// File: tb/tb_controller_fwft_fifo.sv
// Directed bench for controller_fwft_fifo at depth 5, width 8.
module tb_controller_fwft_fifo;

   localparam int W  = 8;
   localparam int D  = 5;
   localparam int LW = 3;

   logic          clock, resetn, wrEn, rdEn, clrErr;
   logic [W-1:0]  wrData, rdData;
   logic [LW-1:0] wmarkLevel, level;
   logic          rdValid, fifoFull, fifoEmpty, wMarkFull, overflow, underflow;

   int checks = 0;
   int errors = 0;

   controller_fwft_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clock(clock), .resetn(resetn), .wrEn(wrEn), .wrData(wrData), .rdEn(rdEn),
      .wmarkLevel(wmarkLevel), .clrErr(clrErr), .rdData(rdData), .rdValid(rdValid),
      .fifoFull(fifoFull), .fifoEmpty(fifoEmpty), .wMarkFull(wMarkFull), .level(level),
      .overflow(overflow), .underflow(underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_level"}, 32'(level), 0);
      chk({tag, "_empty"}, 32'(fifoEmpty), 1);
      chk({tag, "_full"}, 32'(fifoFull), 0);
      chk({tag, "_vld"}, 32'(rdValid), 0);
      chk({tag, "_data"}, 32'(rdData), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
      chk({tag, "_udf"}, 32'(underflow), 0);
      chk({tag, "_wmf"}, 32'(wMarkFull), 0);
   endtask

   task automatic push(input logic [W-1:0] d);
      wrEn = 1'b1; wrData = d;
      step();
      wrEn = 1'b0;
   endtask

   logic [W-1:0] q[$];
   logic [31:0]  pat;
   int           pushed, cyc;
   logic         rd, pp, wr;

   initial begin
      resetn = 1'b1; wrEn = 0; rdEn = 0; clrErr = 0; wrData = '0; wmarkLevel = '0;
      #2 resetn = 1'b0;
      #1 chk_reset_vals("rst");
      step();
      resetn = 1'b1;
      step();

      // fill 1..5, fall-through latency, full flag
      for (int i = 1; i <= 5; i++) begin
         wrEn = 1'b1; wrData = W'(i);
         step();
         if (i == 1) chk("ft_k_vld", 32'(rdValid), 0);
         if (i == 2) chk("ft_k1_vld", 32'(rdValid), 0);
         if (i == 3) begin
            chk("ft_k2_vld", 32'(rdValid), 1);
            chk("ft_k2_data", 32'(rdData), 32'h01);
         end
      end
      wrEn = 1'b0;
      chk("fill_level", 32'(level), 5);
      chk("fill_full", 32'(fifoFull), 1);
      step(); step();
      rdEn = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         chk("b2b_vld", 32'(rdValid), 1);
         chk("b2b_data", 32'(rdData), 32'(i));
         step();
      end
      rdEn = 1'b0;
      chk("drain_empty", 32'(fifoEmpty), 1);
      chk("drain_level", 32'(level), 0);

      // overflow at full, then push+pop at full
      for (int i = 0; i < 5; i++) push(W'(8'h11 + i));
      step(); step();
      push(8'hAA);
      chk("ovf_level", 32'(level), 5);
      chk("ovf_set", 32'(overflow), 1);
      clrErr = 1'b1; step(); clrErr = 1'b0;
      chk("ovf_clr", 32'(overflow), 0);
      chk("pp_head", 32'(rdData), 32'h11);
      wrEn = 1'b1; wrData = 8'hBB; rdEn = 1'b1;
      step();
      wrEn = 1'b0; rdEn = 1'b0;
      chk("pp_level", 32'(level), 5);
      chk("pp_ovf", 32'(overflow), 0);
      step(); step();
      rdEn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("pp_vld", 32'(rdValid), 1);
         chk("pp_data", 32'(rdData), (i < 4) ? 32'(8'h12 + i) : 32'hBB);
         step();
      end
      rdEn = 1'b0;
      chk("pp_empty", 32'(fifoEmpty), 1);

      // underflow, set-wins-over-clear
      rdEn = 1'b1; step(); rdEn = 1'b0;
      chk("udf_set", 32'(underflow), 1);
      chk("udf_level", 32'(level), 0);
      rdEn = 1'b1; clrErr = 1'b1; step();
      chk("udf_setwins", 32'(underflow), 1);
      rdEn = 1'b0; step(); clrErr = 1'b0;
      chk("udf_clr", 32'(underflow), 0);

      // watermark
      wmarkLevel = 3'd3;
      push(8'h21); push(8'h22);
      chk("wm_l2", 32'(wMarkFull), 0);
      push(8'h23);
      chk("wm_l3", 32'(wMarkFull), 1);
      rdEn = 1'b1; step(); rdEn = 1'b0;
      chk("wm_pop", 32'(wMarkFull), 0);
      chk("wm_pop_lvl", 32'(level), 2);
      wmarkLevel = 3'd0;
      push(8'h24);
      chk("wm_zero", 32'(wMarkFull), 0);
      wmarkLevel = 3'd6;
      push(8'h25); push(8'h26);
      chk("wm_over_full", 32'(fifoFull), 1);
      chk("wm_over", 32'(wMarkFull), 0);
      wmarkLevel = 3'd5;
      #1 chk("wm_eq_depth", 32'(wMarkFull), 1);
      wmarkLevel = 3'd0;
      rdEn = 1'b1; repeat (8) step(); rdEn = 1'b0;
      chk("wm_drain", 32'(fifoEmpty), 1);
      clrErr = 1'b1; step(); clrErr = 1'b0;

      // 20 pushes with patterned pops, pointer wrap, then reset mid-stream
      pat = 32'b1011_0010_1101_0001_1100_1010_0110_1001;
      pushed = 0; cyc = 0;
      while (pushed < 20 && cyc < 200) begin
         rd = pat[cyc % 32];
         pp = rd && rdValid;
         if (pp) chk("str_data", 32'(rdData), (q.size() > 0) ? 32'(q[0]) : 32'hDEAD);
         wr = (q.size() < D) || pp;
         rdEn = rd; wrEn = wr; wrData = W'(8'h40 + pushed);
         step();
         if (pp && q.size() > 0) void'(q.pop_front());
         if (wr) begin q.push_back(W'(8'h40 + pushed)); pushed++; end
         chk("str_level", 32'(level), 32'(q.size()));
         cyc++;
      end
      rdEn = 1'b0; wrEn = 1'b0;
      chk("str_done", 32'(pushed), 20);
      chk("str_ovf", 32'(overflow), 0);
      resetn = 1'b0;
      q.delete();
      #1 chk_reset_vals("midrst");
      step();
      resetn = 1'b1;
      step();
      wrEn = 1'b1; wrData = 8'h5A; rdEn = 1'b0;
      step();
      wrEn = 1'b0;
      step();
      chk("post_k1_vld", 32'(rdValid), 0);
      step();
      chk("post_vld", 32'(rdValid), 1);
      chk("post_data", 32'(rdData), 32'h5A);

      // level=1 simultaneous push and pop
      wrEn = 1'b1; wrData = 8'h5B; rdEn = 1'b1;
      step();
      wrEn = 1'b0; rdEn = 1'b0;
      chk("l1_level", 32'(level), 1);
      chk("l1_vld_k", 32'(rdValid), 0);
      step();
      chk("l1_vld_k1", 32'(rdValid), 0);
      step();
      chk("l1_vld_k2", 32'(rdValid), 1);
      chk("l1_data", 32'(rdData), 32'h5B);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
